// File: rtl/scan_test_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : scan_test_controller_if
// Description : Handshake, scan-pin and result bundle for scan_test_controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface scan_test_controller_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [7:0]       pattern;
  logic             ready;
  logic             scan_en;
  logic             scan_in;
  logic             scan_out;
  logic             result_valid;
  logic [7:0]       result;
  logic             pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  // System side: issues requests, hosts the chain, observes results.
  modport master (
    output start, pattern, scan_out,
    input  ready, scan_en, scan_in, result_valid, result, pass, pass_cnt, fail_cnt
  );

  modport slave (
    input  start, pattern, scan_out,
    output ready, scan_en, scan_in, result_valid, result, pass, pass_cnt, fail_cnt
  );
endinterface
`default_nettype wire

// File: rtl/scan_test_controller.sv
`default_nettype none
// ============================================================================
// Module      : scan_test_controller
// Description : Loads a pattern into an 8-bit multiplier scan chain, captures,
//               unloads the product and scores it against a 4x4 golden product.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_test_controller #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  scan_test_controller_if.slave bus
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_LOAD    = 3'd1;
  localparam logic [2:0] c_CAPTURE = 3'd2;
  localparam logic [2:0] c_UNLOAD  = 3'd3;
  localparam logic [2:0] c_DONE    = 3'd4;

  localparam logic [2:0]       c_LAST_IDX = 3'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_pat;
  logic [7:0]       r_golden;
  logic [7:0]       r_resp;
  logic [7:0]       r_result;
  logic             r_pass;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;

  logic [7:0]       w_golden;
  logic [7:0]       w_resp_next;
  logic             w_match;
  logic             w_last_bit;

  assign w_golden   = {4'b0000, bus.pattern[3:0]} * {4'b0000, bus.pattern[7:4]};
  assign w_last_bit = (r_bit_idx == c_LAST_IDX);

  // Response including the bit arriving this cycle, so DONE can score it.
  always_comb begin
    w_resp_next             = r_resp;
    w_resp_next[r_bit_idx]  = bus.scan_out;
  end

  assign w_match = (w_resp_next == r_golden);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_bit_idx  <= 3'd0;
      r_pat      <= 8'd0;
      r_golden   <= 8'd0;
      r_resp     <= 8'd0;
      r_result   <= 8'd0;
      r_pass     <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.start) begin
            r_pat     <= bus.pattern;
            r_golden  <= w_golden;
            r_bit_idx <= 3'd0;
            r_state   <= c_LOAD;
          end
        end
        c_LOAD: begin
          r_bit_idx <= r_bit_idx + 3'd1;
          if (w_last_bit) begin
            r_state <= c_CAPTURE;
          end
        end
        c_CAPTURE: begin
          r_state <= c_UNLOAD;
        end
        c_UNLOAD: begin
          r_resp    <= w_resp_next;
          r_bit_idx <= r_bit_idx + 3'd1;
          if (w_last_bit) begin
            r_result <= w_resp_next;
            r_pass   <= w_match;
            if (w_match) begin
              if (r_pass_cnt != c_CNT_MAX) r_pass_cnt <= r_pass_cnt + c_CNT_ONE;
            end else begin
              if (r_fail_cnt != c_CNT_MAX) r_fail_cnt <= r_fail_cnt + c_CNT_ONE;
            end
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Pin outputs decode registered state only; reset forces them off at once.
  assign bus.ready        = (r_state == c_IDLE);
  assign bus.scan_en      = (r_state == c_LOAD) || (r_state == c_UNLOAD);
  assign bus.scan_in      = (r_state == c_LOAD) && r_pat[r_bit_idx];
  assign bus.result_valid = (r_state == c_DONE);
  assign bus.result       = r_result;
  assign bus.pass         = r_pass;
  assign bus.pass_cnt     = r_pass_cnt;
  assign bus.fail_cnt     = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_scan_test_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_test_controller
// Description : Self-checking bench with an 8-bit multiplier scan chain model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_test_controller;

  logic clk;
  logic rst;
  logic fault;
  logic [7:0] chain;

  int n_cmp;
  int n_fail;
  int m_pass;
  int m_fail;

  scan_test_controller_if #(.CNT_W(8)) bus ();

  scan_test_controller #(.CHAIN_LEN(8), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier scan chain: shift toward bit 0 when enabled, else capture lo*hi.
  always @(posedge clk) begin
    if (bus.scan_en) chain <= {bus.scan_in, chain[7:1]};
    else             chain <= {4'b0000, chain[3:0]} * {4'b0000, chain[7:4]};
  end
  assign bus.scan_out = fault ? 1'b0 : chain[0];

  function automatic int golden_of(input logic [7:0] p);
    return int'(p[3:0]) * int'(p[7:4]);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Runs one test from an IDLE negedge; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_one(input logic [7:0] p, output int lat, output logic [7:0] res,
                         output logic ps, output logic [19:0] en_seq,
                         output logic [19:0] in_seq, output bit rdy_low);
    bus.start   = 1'b1;
    bus.pattern = p;
    lat = -1; res = 8'h00; ps = 1'b0; en_seq = '0; in_seq = '0; rdy_low = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start   = 1'b0;
        bus.pattern = 8'($urandom);
      end
      if (k < 20) begin
        en_seq[k] = bus.scan_en;
        in_seq[k] = bus.scan_in;
      end
      if (lat < 0 && bus.ready) rdy_low = 1'b0;
      if (lat < 0 && bus.result_valid) begin
        lat = k; res = bus.result; ps = bus.pass;
      end
      if (lat > 0 && k == lat + 1) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.pattern = 8'h00; fault = 1'b0;
    #2;
    n_cmp++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    n_cmp++; if (bus.scan_en !== 1'b0 || bus.scan_in !== 1'b0) begin n_fail++; $display("FAIL reset_scan got en=%b in=%b want 0/0", bus.scan_en, bus.scan_in); end
    n_cmp++; if (bus.result_valid !== 1'b0 || bus.result !== 8'h00 || bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset_result got v=%b r=%h p=%b want 0/00/0", bus.result_valid, bus.result, bus.pass); end
    n_cmp++; if (bus.pass_cnt !== 8'd0 || bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.pass_cnt, bus.fail_cnt); end
    m_pass = 0; m_fail = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_known_patterns;
    int lat; logic [7:0] res; logic ps; logic [19:0] en, in; bit rl;
    logic [19:0] exp_en;
    run_one(8'h32, lat, res, ps, en, in, rl);
    m_pass = sat_inc(m_pass);
    n_cmp++; if (in[8:1] !== 8'h32) begin n_fail++; $display("FAIL h32_scan_in got=%b want=%b", in[8:1], 8'h32); end
    n_cmp++; if (lat !== 18) begin n_fail++; $display("FAIL h32_latency got=%0d want=18", lat); end
    n_cmp++; if (res !== 8'h06 || ps !== 1'b1) begin n_fail++; $display("FAIL h32_result got=%h/%b want=06/1", res, ps); end
    n_cmp++; if (int'(bus.pass_cnt) !== m_pass) begin n_fail++; $display("FAIL h32_pass_cnt got=%0d want=%0d", bus.pass_cnt, m_pass); end
    n_cmp++; if (!rl) begin n_fail++; $display("FAIL h32_ready got=high_during_test want=low"); end

    run_one(8'hFF, lat, res, ps, en, in, rl);
    m_pass = sat_inc(m_pass);
    n_cmp++; if (res !== 8'hE1 || ps !== 1'b1) begin n_fail++; $display("FAIL hFF_result got=%h/%b want=e1/1", res, ps); end

    run_one(8'h00, lat, res, ps, en, in, rl);
    m_pass = sat_inc(m_pass);
    exp_en = '0;
    for (int k = 1; k <= 17; k++) exp_en[k] = (k != 9);
    n_cmp++; if (res !== 8'h00 || ps !== 1'b1) begin n_fail++; $display("FAIL h00_result got=%h/%b want=00/1", res, ps); end
    n_cmp++; if (en !== exp_en) begin n_fail++; $display("FAIL h00_scan_en got=%b want=%b", en, exp_en); end
    n_cmp++; if (in[19:9] !== 11'd0) begin n_fail++; $display("FAIL h00_scan_in_idle got=%b want=0", in[19:9]); end
    n_cmp++; if (int'(bus.pass_cnt) !== m_pass || int'(bus.fail_cnt) !== m_fail) begin n_fail++; $display("FAIL known_cnt got=%0d/%0d want=%0d/%0d", bus.pass_cnt, bus.fail_cnt, m_pass, m_fail); end
  endtask

  task automatic test_fault;
    int lat; logic [7:0] res; logic ps; logic [19:0] en, in; bit rl;
    fault = 1'b1;
    run_one(8'h32, lat, res, ps, en, in, rl);
    fault = 1'b0;
    m_fail = sat_inc(m_fail);
    n_cmp++; if (res !== 8'h00 || ps !== 1'b0) begin n_fail++; $display("FAIL fault_result got=%h/%b want=00/0", res, ps); end
    n_cmp++; if (int'(bus.fail_cnt) !== m_fail || int'(bus.pass_cnt) !== m_pass) begin n_fail++; $display("FAIL fault_cnt got=%0d/%0d want=%0d/%0d", bus.pass_cnt, bus.fail_cnt, m_pass, m_fail); end
  endtask

  task automatic test_back_to_back;
    logic [38:1] rdy_obs, vld_obs, rdy_exp, vld_exp;
    logic [7:0]  r1, r2;
    rdy_exp = '0; rdy_exp[19] = 1'b1;
    vld_exp = '0; vld_exp[18] = 1'b1; vld_exp[37] = 1'b1; rdy_exp[38] = 1'b1;
    r1 = 8'hxx; r2 = 8'hxx;
    bus.start = 1'b1; bus.pattern = 8'h21;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k == 1)  bus.pattern = 8'h44;
      if (k == 20) bus.pattern = 8'($urandom);
      if (k == 37) bus.start = 1'b0;
      rdy_obs[k] = bus.ready;
      vld_obs[k] = bus.result_valid;
      if (k == 18) r1 = bus.result;
      if (k == 37) r2 = bus.result;
    end
    m_pass = sat_inc(sat_inc(m_pass));
    n_cmp++; if (rdy_obs !== rdy_exp) begin n_fail++; $display("FAIL b2b_ready got=%b want=%b", rdy_obs, rdy_exp); end
    n_cmp++; if (vld_obs !== vld_exp) begin n_fail++; $display("FAIL b2b_valid got=%b want=%b", vld_obs, vld_exp); end
    n_cmp++; if (r1 !== 8'h02 || r2 !== 8'h10) begin n_fail++; $display("FAIL b2b_results got=%h,%h want=02,10", r1, r2); end
    n_cmp++; if (int'(bus.pass_cnt) !== m_pass) begin n_fail++; $display("FAIL b2b_pass_cnt got=%0d want=%0d", bus.pass_cnt, m_pass); end
  endtask

  task automatic test_random;
    int lat; logic [7:0] res; logic ps; logic [19:0] en, in; bit rl;
    logic [7:0] p; int g, er; bit f, ep;
    for (int i = 0; i < 24; i++) begin
      p = 8'($urandom);
      f = ($urandom_range(0, 3) == 0);
      fault = f;
      run_one(p, lat, res, ps, en, in, rl);
      fault = 1'b0;
      g  = golden_of(p);
      er = f ? 0 : g;
      ep = (er == g);
      if (ep) m_pass = sat_inc(m_pass); else m_fail = sat_inc(m_fail);
      n_cmp++; if (lat !== 18 || int'(res) !== er || ps !== ep) begin n_fail++; $display("FAIL rand_result p=%h fault=%0d got lat=%0d r=%h p=%b want lat=18 r=%h p=%b", p, f, lat, res, ps, er[7:0], ep); end
      n_cmp++; if (in[8:1] !== p) begin n_fail++; $display("FAIL rand_scan_in got=%h want=%h", in[8:1], p); end
      n_cmp++; if (int'(bus.pass_cnt) !== m_pass || int'(bus.fail_cnt) !== m_fail) begin n_fail++; $display("FAIL rand_cnt got=%0d/%0d want=%0d/%0d", bus.pass_cnt, bus.fail_cnt, m_pass, m_fail); end
    end
  endtask

  task automatic test_saturation;
    int lat; logic [7:0] res; logic ps; logic [19:0] en, in; bit rl;
    fault = 1'b1;
    for (int i = 0; i < 260; i++) begin
      run_one(8'h32, lat, res, ps, en, in, rl);
      m_fail = sat_inc(m_fail);
      n_cmp++; if (int'(bus.fail_cnt) !== m_fail) begin n_fail++; $display("FAIL sat_fail_cnt iter=%0d got=%0d want=%0d", i, bus.fail_cnt, m_fail); end
    end
    fault = 1'b0;
    run_one(8'h32, lat, res, ps, en, in, rl);
    m_pass = sat_inc(m_pass);
    n_cmp++; if (int'(bus.fail_cnt) !== 255 || int'(bus.pass_cnt) !== m_pass) begin n_fail++; $display("FAIL sat_other_cnt got=%0d/%0d want=%0d/255", bus.pass_cnt, bus.fail_cnt, m_pass); end
  endtask

  task automatic test_reset_midop;
    int lat; logic [7:0] res; logic ps; logic [19:0] en, in; bit rl;
    bus.start = 1'b1; bus.pattern = 8'h32;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    n_cmp++; if (bus.scan_en !== 1'b1 || bus.ready !== 1'b0) begin n_fail++; $display("FAIL midop_pre got en=%b rdy=%b want 1/0", bus.scan_en, bus.ready); end
    rst = 1'b1;
    #1;
    m_pass = 0; m_fail = 0;
    n_cmp++; if (bus.scan_en !== 1'b0 || bus.ready !== 1'b1) begin n_fail++; $display("FAIL midop_async got en=%b rdy=%b want 0/1", bus.scan_en, bus.ready); end
    n_cmp++; if (bus.pass_cnt !== 8'd0 || bus.fail_cnt !== 8'd0) begin n_fail++; $display("FAIL midop_cnt got=%0d/%0d want=0/0", bus.pass_cnt, bus.fail_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_one(8'h32, lat, res, ps, en, in, rl);
    m_pass = sat_inc(m_pass);
    n_cmp++; if (lat !== 18 || res !== 8'h06 || ps !== 1'b1) begin n_fail++; $display("FAIL midop_retest got lat=%0d r=%h p=%b want 18/06/1", lat, res, ps); end
    n_cmp++; if (int'(bus.pass_cnt) !== m_pass || int'(bus.fail_cnt) !== m_fail) begin n_fail++; $display("FAIL midop_retest_cnt got=%0d/%0d want=%0d/%0d", bus.pass_cnt, bus.fail_cnt, m_pass, m_fail); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_known_patterns();
    test_fault();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
